// File: rtl/iq_pkg.sv
// Shared defaults and width helpers for the IQ modulator output stages.
package iq_pkg;

    localparam int IQ_NP = 30;
    localparam int IQ_OW = 16;

    // Difference of two unsigned NP-bit products needs one extra sign bit.
    function automatic int iq_nd(input int np);
        return np + 1;
    endfunction

    function automatic int iq_drop(input int nd, input int ow);
        return nd - ow;
    endfunction

endpackage

// File: rtl/conv_round.sv
// Convergent (round-half-to-even) rounding of a signed ND-bit word to OW bits,
// with clamping at the positive maximum. The negative side cannot overflow.
module conv_round
    import iq_pkg::*;
#(
    parameter int ND = 31,
    parameter int OW = 16
) (
    input  logic [ND-1:0] d_i,
    output logic [OW-1:0] q_o
);

    localparam int DROP = iq_drop(ND, OW);

    generate
        if (DROP == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_round
            localparam logic [DROP-1:0] HALF   = DROP'(1) << (DROP - 1);
            localparam logic [OW-1:0]   POSMAX = {1'b0, {(OW-1){1'b1}}};

            logic [OW-1:0]   keep;
            logic [DROP-1:0] frac;
            logic            round_up;

            assign keep     = d_i[ND-1:DROP];
            assign frac     = d_i[DROP-1:0];
            assign round_up = (frac > HALF) || ((frac == HALF) && keep[0]);
            assign q_o      = (round_up && (keep != POSMAX)) ? keep + OW'(1) : keep;
        end
    endgenerate

endmodule

// File: rtl/iq_sum_round.sv
// I/Q product combiner: signed difference, convergent rounding to the DAC width,
// valid/ready output, and the shared pipeline enable for the upstream multipliers.
module iq_sum_round
    import iq_pkg::*;
#(
    parameter int NP = IQ_NP,
    parameter int OW = IQ_OW
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [NP-1:0] i_p_i,
    input  logic          i_aux_i,
    input  logic [NP-1:0] i_p_q,
    input  logic          i_aux_q,
    output logic          o_ce,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_err
);

    localparam int ND = iq_nd(NP);

    logic [ND-1:0] d1_q, d1_d;
    logic          v1_q, v1_d;
    logic [OW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [OW-1:0] rounded;
    logic          ce;

    // Combinational so a stalled output freezes the multipliers in the same cycle.
    assign ce = !valid_q || i_ready;

    conv_round #(
        .ND (ND),
        .OW (OW)
    ) u_round (
        .d_i (d1_q),
        .q_o (rounded)
    );

    always_comb begin
        d1_d    = d1_q;
        v1_d    = v1_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (ce) begin
            d1_d    = {1'b0, i_p_i} - {1'b0, i_p_q};
            v1_d    = i_aux_i;
            data_d  = rounded;
            valid_d = v1_q;
            err_d   = err_q | (i_aux_i ^ i_aux_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            d1_q    <= '0;
            v1_q    <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            d1_q    <= d1_d;
            v1_q    <= v1_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign o_ce    = ce;
    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_err   = err_q;

endmodule

// File: doc/iq_sum_round.md
# iq_sum_round

Output combiner for the IQ modulator datapath. It consumes the unsigned products of the I-branch and Q-branch unsigned multipliers (I·cos and Q·sin). It forms their signed difference, applies convergent rounding and saturation to the DAC word width, and presents the sample on a valid/ready port. It also generates the clock-enable that stalls both upstream multipliers when the output is back-pressured.

## Interface
Parameters:
- `NP`, 30: width of each unsigned product input.
- `OW`, 16: width of the signed output sample; must satisfy OW ≤ NP.

Ports:
- `i_clk`, in, 1: the single clock.
- `i_reset_n`, in, 1: reset, asynchronous and active-low.
- `i_p_i`, in, NP: I-branch product, unsigned.
- `i_aux_i`, in, 1: I-branch aux bit; marks `i_p_i` as a valid sample.
- `i_p_q`, in, NP: Q-branch product, unsigned.
- `i_aux_q`, in, 1: Q-branch aux bit; marks `i_p_q` as a valid sample.
- `o_ce`, out, 1: pipeline enable; drives `i_ce` of both multipliers and of this block's own stages.
- `o_valid`, out, 1: output sample valid.
- `i_ready`, in, 1: downstream accepts the sample.
- `o_data`, out, OW: signed output sample.
- `o_err`, out, 1: sticky flag; set on I/Q aux misalignment.

## Operation
- Internal widths:
  - ND = NP+1 is the width of the difference.
  - DROP = ND−OW is the number of low bits removed by rounding.
- `o_ce` is computed as `!o_valid || i_ready`. It is combinational, and every register in the block advances only when `o_ce` is 1.
- Stage 1 (register `d1`, with valid bit `v1`):
  - `d1` = {1'b0,`i_p_i`} − {1'b0,`i_p_q`}, treated as signed ND bits.
  - `v1` = `i_aux_i`.
- Stage 2 (the output register, updated from stage 1):
  - Split `d1` into `keep` = `d1`[ND−1:DROP] and `frac` = `d1`[DROP−1:0].
  - Let `half` = 1<<(DROP−1).
  - Round up when `frac` > `half`, or when `frac` == `half` and `keep`[0] = 1 (round half to even).
  - If rounding up would take `keep` past the positive maximum 2^(OW−1)−1, hold `keep` at that maximum (saturate).
  - The negative side cannot overflow, so no clamp is applied there.
  - When DROP = 0, `keep` = `d1` and no rounding is done.
  - `o_data` takes the rounded value and `o_valid` takes `v1`.
- A sample with `v1` = 0 still loads `o_data`, but `o_valid` = 0. Consumers ignore `o_data` whenever `o_valid` is low.
- Aux check: on any cycle with `o_ce` = 1 and `i_aux_i` ≠ `i_aux_q`, set `o_err` = 1. The flag holds until reset. The data path continues, and `i_aux_i` alone qualifies the sample.

## Timing
- Reset asserted (asynchronous): `d1`, `v1`, `o_data`, `o_valid` and `o_err` all go to 0. `o_ce` then reads 1.
- Latency: 2 enabled cycles from product and aux at the inputs to `o_data`/`o_valid`. The full chain from the multiplier inputs is 3+2 = 5 enabled cycles.
- Handshake:
  - A transfer occurs when `o_valid` and `i_ready` are both 1.
  - `o_data` and `o_valid` stay stable while `o_valid` = 1 and `i_ready` = 0.
  - `o_ce` = 0 in that state, freezing the multipliers and stage 1. No sample is lost or duplicated.
- Back-to-back throughput is 1 sample per cycle while `i_ready` = 1.
- `i_ready` reaches `o_ce` through a combinational path only. That path must meet single-cycle timing into the multiplier enables.
- When reset is released mid-stream, the pipeline restarts empty. Samples held in flight when reset was asserted are discarded.
- If `i_ready` rises in the same cycle a new `v1` arrives, the current output transfers and the new sample loads into the output register on that edge.

## Structure
- Shared package `iq_pkg` holds:
  - defaults `IQ_NP` = 30 and `IQ_OW` = 16;
  - localparam helpers for ND and DROP.
- Sub-module `conv_round` (combinational) takes a signed ND-bit input and produces the signed OW-bit rounded, saturated result. It is parameterised by ND and OW and is reused by other output stages.
- The top level holds stage 1, the output register, the `o_ce` logic and `o_err`.

## Test plan
All scenarios use NP = 30 and OW = 16, with `i_ready` = 1 and matched aux unless stated otherwise.
- Exact value: `i_p_i` = 0x8000, `i_p_q` = 0 → after 2 cycles `o_data` = 1 and `o_valid` = 1.
- Tie to even, low side: `i_p_i` = 0x4000, `i_p_q` = 0 → `o_data` = 0. Tie to even, high side: `i_p_i` = 0xC000 → `o_data` = 2.
- Extremes:
  - `i_p_i` = 2^30−1, `i_p_q` = 0 → `o_data` = 0x7FFF (saturated).
  - `i_p_i` = 0, `i_p_q` = 2^30−1 → `o_data` = 0x8000.
- Back-pressure: stream 5 distinct samples and hold `i_ready` = 0 for 3 cycles while `o_valid` = 1.
  - Required: `o_ce` = 0, `o_data` held stable, and all 5 samples delivered in order with none dropped or duplicated.
- Aux mismatch: one cycle with `i_aux_i` = 1 and `i_aux_q` = 0 → `o_err` = 1 from the next edge and still 1 after 100 cycles. `i_reset_n` low clears it to 0.
- Reset mid-stream: pulse `i_reset_n` low between edges with 2 samples in flight.
  - Required: all outputs go to 0 immediately, with no clock edge needed.
  - Required: the first post-reset sample appears exactly 2 enabled cycles after it is applied.
